// File: rtl/lms_pkg.sv
// Shared widths and FSM state encoding for the LMS/FIR compute engine.
package lms_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 32;
    localparam int OUT_W    = 32;
    localparam int WADJ_W   = 32;
    localparam int WUPD_W   = WADJ_W + SAMPLE_W;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MAC  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/lms_sat.sv
// Combinational signed saturator: clamps a wide two's-complement value to OUT_W bits.
module lms_sat #(
    parameter int IN_W  = 34,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // The value fits when every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] top_bits;

    assign top_bits = din[IN_W-1:OUT_W-1];

    always_comb begin
        if ((&top_bits) || !(|top_bits)) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/lms_fir_engine.sv
// Sequential FIR/LMS engine: one tap per cycle MAC, saturated Q2.30 output, one-cycle fir_done.
// Define LMS_ADAPT_EN to enable the in-pass LMS weight update driven by weight_adjust.
module lms_fir_engine #(
    parameter int NTAPS = 16,
    parameter int FRAC  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fir_go,
    input  logic [31:0]              x_in,
    input  logic [31:0]              weight_adjust,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [15:0]              coef_wdata,
    output logic [31:0]              fir_out,
    output logic                     fir_done,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    import lms_pkg::*;

    localparam int IDX_W = $clog2(NTAPS);
    localparam int ACC_W = PROD_W + IDX_W;

    // Handshake: fir_go is a request accepted only while busy=0; the matching
    // response is a single fir_done cycle, and fir_out holds until the next one.

    state_t state_q;
    state_t state_d;

    logic start_en;
    logic mac_en;
    logic done_en;
    logic coef_wr;
    logic last_tap;

    logic [IDX_W-1:0]           idx_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [SAMPLE_W-1:0] x_q [NTAPS];
    logic signed [SAMPLE_W-1:0] w_q [NTAPS];
    logic signed [SAMPLE_W-1:0] x_sel;
    logic signed [SAMPLE_W-1:0] w_sel;
    logic signed [PROD_W-1:0]   prod;
    logic signed [OUT_W-1:0]    acc_sat;
    logic [31:0]                fir_out_q;
    logic                       fir_done_q;

    assign last_tap = (idx_q == IDX_W'(NTAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fir_go) state_d = ST_MAC;
            ST_MAC:  if (last_tap) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_en = (state_q == ST_IDLE) && fir_go;
        coef_wr  = (state_q == ST_IDLE) && coef_we;
        mac_en   = (state_q == ST_MAC);
        done_en  = (state_q == ST_DONE);
        busy     = (state_q == ST_MAC) || (state_q == ST_DONE);
    end

    assign state_dbg = state_q;

    assign x_sel    = x_q[idx_q];
    assign w_sel    = w_q[idx_q];
    assign prod     = $signed({{(PROD_W-SAMPLE_W){w_sel[SAMPLE_W-1]}}, w_sel})
                    * $signed({{(PROD_W-SAMPLE_W){x_sel[SAMPLE_W-1]}}, x_sel});
    assign acc_next = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

    lms_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_out (
        .din  (acc_q),
        .dout (acc_sat)
    );

`ifdef LMS_ADAPT_EN
    logic signed [WADJ_W-1:0]   wa_q;
    logic signed [WUPD_W-1:0]   upd_prod;
    logic signed [WUPD_W-1:0]   upd_sh;
    logic signed [WUPD_W:0]     upd_sum;
    logic signed [SAMPLE_W-1:0] w_new;
    logic                       unused_bits;

    // Q2.30 adjust times Q1.15 sample is Q3.45; shifting by 2*FRAC lands in Q1.15.
    assign upd_prod = $signed({{SAMPLE_W{wa_q[WADJ_W-1]}}, wa_q})
                    * $signed({{WADJ_W{x_sel[SAMPLE_W-1]}}, x_sel});
    assign upd_sh   = upd_prod >>> (2 * FRAC);
    assign upd_sum  = {{(WUPD_W-SAMPLE_W+1){w_sel[SAMPLE_W-1]}}, w_sel}
                    + {upd_sh[WUPD_W-1], upd_sh};

    lms_sat #(.IN_W(WUPD_W + 1), .OUT_W(SAMPLE_W)) u_sat_w (
        .din  (upd_sum),
        .dout (w_new)
    );

    assign unused_bits = ^x_in[31:16];
`else
    logic unused_bits;

    assign unused_bits = ^{x_in[31:16], weight_adjust, FRAC[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
                w_q[k] <= '0;
            end
            idx_q      <= '0;
            acc_q      <= '0;
            fir_out_q  <= '0;
            fir_done_q <= 1'b0;
`ifdef LMS_ADAPT_EN
            wa_q       <= '0;
`endif
        end else begin
            fir_done_q <= 1'b0;
            // The write lands before MAC starts, so a same-edge go sees the new weight.
            if (coef_wr) begin
                w_q[coef_addr] <= coef_wdata;
            end
            if (start_en) begin
                for (int k = NTAPS - 1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= x_in[15:0];
                idx_q  <= '0;
                acc_q  <= '0;
`ifdef LMS_ADAPT_EN
                wa_q   <= weight_adjust;
`endif
            end
            if (mac_en) begin
                acc_q <= acc_next;
                idx_q <= idx_q + IDX_W'(1);
`ifdef LMS_ADAPT_EN
                w_q[idx_q] <= w_new;
`endif
            end
            if (done_en) begin
                fir_out_q  <= acc_sat;
                fir_done_q <= 1'b1;
            end
        end
    end

    assign fir_out  = fir_out_q;
    assign fir_done = fir_done_q;

endmodule

// File: tb/tb_lms_fir_engine.sv
// Self-checking bench for lms_fir_engine (NTAPS=4, FRAC=15); honours LMS_ADAPT_EN when defined.
module tb_lms_fir_engine;

    import lms_pkg::*;

    localparam int NTAPS = 4;
    localparam int FRAC  = 15;

    logic        clk;
    logic        rst;
    logic        fir_go;
    logic [31:0] x_in;
    logic [31:0] weight_adjust;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic [31:0] fir_out;
    logic        fir_done;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] m_x [NTAPS];
    logic signed [15:0] m_w [NTAPS];
    logic [31:0]        exp_q [$];

    lms_fir_engine #(.NTAPS(NTAPS), .FRAC(FRAC)) dut (
        .clk           (clk),
        .rst           (rst),
        .fir_go        (fir_go),
        .x_in          (x_in),
        .weight_adjust (weight_adjust),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_wdata    (coef_wdata),
        .fir_out       (fir_out),
        .fir_done      (fir_done),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return 32'(v);
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        if (v > 64'sd32767) return 16'h7FFF;
        if (v < -64'sd32768) return 16'h8000;
        return 16'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            m_x[k] = '0;
            m_w[k] = '0;
        end
        exp_q.delete();
    endtask

    // One filter pass as arithmetic: shift in, dot product, then (optionally) LMS update.
    task automatic model_go(input logic [15:0] xs, input logic [31:0] wa, output logic [31:0] e);
        longint sum;
        longint upd;
        for (int k = NTAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = xs;
        sum = 0;
        for (int k = 0; k < NTAPS; k++) sum += longint'(m_w[k]) * longint'(m_x[k]);
        upd = 0;
`ifdef LMS_ADAPT_EN
        for (int k = 0; k < NTAPS; k++) begin
            upd = (longint'($signed(wa)) * longint'(m_x[k])) >>> (2 * FRAC);
            m_w[k] = sat16(longint'(m_w[k]) + upd);
        end
`else
        if (wa != 0) upd = 0;
`endif
        e = sat32(sum);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        fir_go = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int a, input logic [15:0] d);
        coef_we = 1'b1;
        coef_addr = 2'(a);
        coef_wdata = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
        m_w[a] = d;
        @(negedge clk);
    endtask

    // Starts and ends just after a falling edge; optional same-edge coefficient write.
    task automatic do_go(input logic [15:0] xs, input logic [31:0] wa, input bit hold_check,
                         input bit wr, input int waddr, input logic [15:0] wd, input string tag);
        logic [31:0] e;
        int n;
        bit seen;
        if (wr) m_w[waddr] = wd;
        model_go(xs, wa, e);
        exp_q.push_back(e);
        x_in = {16'($urandom), xs};
        weight_adjust = wa;
        coef_we = wr;
        coef_addr = 2'(waddr);
        coef_wdata = wd;
        fir_go = 1'b1;
        @(posedge clk);
        #1;
        fir_go = 1'b0;
        coef_we = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (fir_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no fir_done within 20 cycles", tag);
            void'(exp_q.pop_front());
        end else begin
            if (n !== NTAPS + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d edges, expected %0d", tag, n, NTAPS + 1);
            end
            checks++;
            e = exp_q.pop_front();
            if (fir_out !== e) begin
                errors++;
                $display("FAIL %s fir_out: got %h, expected %h", tag, fir_out, e);
            end
            if (hold_check) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (fir_done !== 1'b0 || fir_out !== e || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold: done=%b out=%h busy=%b, expected done=0 out=%h busy=0",
                             tag, fir_done, fir_out, busy, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (fir_out !== 32'h0) begin
            errors++;
            $display("FAIL reset fir_out: got %h, expected 00000000", fir_out);
        end
        checks++;
        if (fir_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: done=%b busy=%b, expected 0 0", fir_done, busy);
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset state: got %0d, expected %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        write_coef(0, 16'h4000);
        do_go(16'h2000, 32'h0, 1'b1, 1'b0, 0, 16'h0, "latency");
        checks++;
        if (fir_out !== 32'h0800_0000) begin
            errors++;
            $display("FAIL latency const: got %h, expected 08000000", fir_out);
        end
    endtask

    task automatic test_delay_line();
        logic [15:0] xs [4];
        xs = '{16'h4000, 16'h0, 16'h0, 16'h0};
        apply_reset();
        write_coef(3, 16'h7FFF);
        for (int i = 0; i < 4; i++) do_go(xs[i], 32'h0, 1'b1, 1'b0, 0, 16'h0, "delay_line");
        checks++;
        if (fir_out !== 32'h1FFF_C000) begin
            errors++;
            $display("FAIL delay_line const: got %h, expected 1fffc000", fir_out);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h8000);
        for (int i = 0; i < 4; i++) do_go(16'h8000, 32'h0, 1'b1, 1'b0, 0, 16'h0, "out_sat");
        checks++;
        if (fir_out !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL out_sat const: got %h, expected 7fffffff", fir_out);
        end
    endtask

`ifdef LMS_ADAPT_EN
    task automatic test_adapt();
        apply_reset();
        do_go(16'h4000, 32'h4000_0000, 1'b1, 1'b0, 0, 16'h0, "adapt_first");
        for (int i = 0; i < 4; i++) do_go(16'h0, 32'h0, 1'b0, 1'b0, 0, 16'h0, "adapt_flush");
        do_go(16'h4000, 32'h0, 1'b1, 1'b0, 0, 16'h0, "adapt_use");
        checks++;
        if (fir_out !== 32'h1000_0000) begin
            errors++;
            $display("FAIL adapt const: got %h, expected 10000000", fir_out);
        end
        apply_reset();
        write_coef(0, 16'h7F00);
        do_go(16'h4000, 32'h4000_0000, 1'b1, 1'b0, 0, 16'h0, "wsat_first");
        do_go(16'h4000, 32'h0, 1'b1, 1'b0, 0, 16'h0, "wsat_use");
    endtask
`endif

    task automatic test_busy();
        logic [31:0] e;
        int n;
        bit seen;
        apply_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'($urandom_range(1, 16'h7FFF)));
        model_go(16'h1234, 32'h0, e);
        exp_q.push_back(e);
        x_in = {16'h0, 16'h1234};
        weight_adjust = 32'h0;
        fir_go = 1'b1;
        @(posedge clk);
        #1 fir_go = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || state_dbg !== ST_MAC) begin
            errors++;
            $display("FAIL busy mid_mac: busy=%b state=%0d, expected 1 %0d", busy, state_dbg, ST_MAC);
        end
        fir_go = 1'b1;
        coef_we = 1'b1;
        coef_addr = 2'd0;
        coef_wdata = ~m_w[0];
        x_in = {16'h0, 16'h7777};
        weight_adjust = 32'h4000_0000;
        @(posedge clk);
        #1;
        fir_go = 1'b0;
        coef_we = 1'b0;
        seen = 1'b0;
        for (n = 3; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (fir_done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        e = exp_q.pop_front();
        if (!seen || n !== NTAPS + 1 || fir_out !== e) begin
            errors++;
            $display("FAIL busy pass: seen=%b edges=%0d out=%h, expected 1 %0d %h", seen, n, fir_out, e, NTAPS + 1);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fir_done) seen = 1'b1;
        end
        checks++;
        if (seen || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL busy no_queue: extra_done=%b state=%0d, expected 0 %0d", seen, state_dbg, ST_IDLE);
        end
        do_go(16'h3A5C, 32'h0, 1'b1, 1'b0, 0, 16'h0, "busy_after");
    endtask

    task automatic test_reset_mid_mac();
        bit seen;
        apply_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'($urandom_range(16'h100, 16'h7FFF)));
        do_go(16'h2345, 32'h0, 1'b1, 1'b0, 0, 16'h0, "rstmac_pre");
        x_in = {16'h0, 16'h1111};
        fir_go = 1'b1;
        @(posedge clk);
        #1 fir_go = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_MAC) begin
            errors++;
            $display("FAIL rstmac state_before: got %0d, expected %0d", state_dbg, ST_MAC);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fir_out !== 32'h0 || fir_done !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmac outputs: out=%h done=%b busy=%b state=%0d, expected 0 0 0 %0d",
                     fir_out, fir_done, busy, state_dbg, ST_IDLE);
        end
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fir_done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rstmac aborted_done: got fir_done after reset, expected none");
        end
        do_go(16'h5A5A, 32'h0, 1'b1, 1'b0, 0, 16'h0, "rstmac_after");
        checks++;
        if (fir_out !== 32'h0) begin
            errors++;
            $display("FAIL rstmac zero_weights: got %h, expected 00000000", fir_out);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'($urandom));
        for (int i = 0; i < 6; i++) do_go(16'($urandom), 32'h0, 1'b0, 1'b0, 0, 16'h0, "back_to_back");
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            bit wr;
            logic [31:0] wa;
            wr = ($urandom_range(0, 2) == 0);
            wa = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, NTAPS - 1), 16'($urandom));
            do_go(16'($urandom), wa, $urandom_range(0, 1) == 1, wr,
                  $urandom_range(0, NTAPS - 1), 16'($urandom), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        fir_go = 1'b0;
        x_in = '0;
        weight_adjust = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_wdata = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_delay_line();
        test_saturation();
`ifdef LMS_ADAPT_EN
        test_adapt();
`endif
        test_busy();
        test_reset_mid_mac();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
